// File: rtl/cfg_region_query_pkg.sv
// Shared types for the region query block: table select, FSM state, rule index width.
package cfg_region_query_pkg;
  localparam int RuleIdxW = 4;
  localparam int MaxRules = 1 << RuleIdxW;

  typedef enum logic [1:0] {
    EXEC    = 2'd0,
    CACHED  = 2'd1,
    NONIDEM = 2'd2,
    RSVD    = 2'd3
  } region_kind_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/config_pkg.sv
// Slice of the core configuration type: only the physical-region rule tables.
package config_pkg;
  localparam int unsigned NrMaxRules = 16;

  typedef struct packed {
    int unsigned               NrNonIdempotentRules;
    logic [NrMaxRules*64-1:0]  NonIdempotentAddrBase;
    logic [NrMaxRules*64-1:0]  NonIdempotentLength;
    int unsigned               NrExecuteRegionRules;
    logic [NrMaxRules*64-1:0]  ExecuteRegionAddrBase;
    logic [NrMaxRules*64-1:0]  ExecuteRegionLength;
    int unsigned               NrCachedRegionRules;
    logic [NrMaxRules*64-1:0]  CachedRegionAddrBase;
    logic [NrMaxRules*64-1:0]  CachedRegionLength;
  } cva6_cfg_t;
endpackage

// File: rtl/cva6_config_pkg.sv
// Default platform map: debug @0 (4 KiB), boot ROM @64 KiB, DRAM @2 GiB (1 GiB).
package cva6_config_pkg;
  localparam config_pkg::cva6_cfg_t cva6_cfg = '{
    NrNonIdempotentRules:  2,
    NonIdempotentAddrBase: '0,
    NonIdempotentLength:   '0,
    NrExecuteRegionRules:  3,
    ExecuteRegionAddrBase: {{13{64'h0}}, 64'h8000_0000, 64'h0001_0000, 64'h0000_0000},
    ExecuteRegionLength:   {{13{64'h0}}, 64'h4000_0000, 64'h0001_0000, 64'h0000_1000},
    NrCachedRegionRules:   1,
    CachedRegionAddrBase:  {{15{64'h0}}, 64'h8000_0000},
    CachedRegionLength:    {{15{64'h0}}, 64'h4000_0000}
  };
endpackage

// File: rtl/cfg_region_query_if.sv
// Query request/response bus; the classifier is the slave side.
interface cfg_region_query_if;
  import cfg_region_query_pkg::*;

  logic                req_valid_i;
  logic                req_ready_o;
  logic [63:0]         req_addr_i;
  logic [1:0]          req_kind_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic                rsp_hit_o;
  logic [RuleIdxW-1:0] rsp_rule_o;
  logic                rsp_err_o;

  modport master (
    output req_valid_i, req_addr_i, req_kind_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_rule_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_kind_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_rule_o, rsp_err_o
  );
endinterface

// File: rtl/cfg_region_match.sv
// Single-rule compare: base <= addr < base+len, end computed in 65 bits so it never wraps.
module cfg_region_match (
  input  logic [63:0] addr_i,
  input  logic [63:0] base_i,
  input  logic [63:0] len_i,
  output logic        match_o
);
  logic [64:0] end_w;

  assign end_w   = {1'b0, base_i} + {1'b0, len_i};
  assign match_o = (len_i != '0) && (addr_i >= base_i) && ({1'b0, addr_i} < end_w);
endmodule

// File: rtl/cfg_region_query.sv
// Sequential physical-region classifier: scans one rule per cycle of the selected table.
// Optional saturating hit/miss counters under `CFG_REGION_QUERY_STATS_EN.
module cfg_region_query
  import cfg_region_query_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = cva6_config_pkg::cva6_cfg
) (
  input  logic                clk_i,
  input  logic                rst_i,
  cfg_region_query_if.slave   bus,
  output logic [15:0]         stat_hits_o,
  output logic [15:0]         stat_misses_o
);

  if (CVA6Cfg.NrExecuteRegionRules > MaxRules ||
      CVA6Cfg.NrCachedRegionRules  > MaxRules ||
      CVA6Cfg.NrNonIdempotentRules > MaxRules) begin : g_cnt_chk
    $error("cfg_region_query: rule count exceeds 4-bit rule index");
  end

  localparam logic [RuleIdxW:0] ExecCnt   = (RuleIdxW+1)'(CVA6Cfg.NrExecuteRegionRules);
  localparam logic [RuleIdxW:0] CachedCnt = (RuleIdxW+1)'(CVA6Cfg.NrCachedRegionRules);
  localparam logic [RuleIdxW:0] NonIdCnt  = (RuleIdxW+1)'(CVA6Cfg.NrNonIdempotentRules);

  state_e              state_q, state_d;
  logic [63:0]         addr_q, addr_d;
  region_kind_e        kind_q, kind_d;
  logic [RuleIdxW-1:0] idx_q, idx_d;
  logic                hit_q, hit_d;
  logic [RuleIdxW-1:0] rule_q, rule_d;
  logic                err_q, err_d;

  logic                req_ready;
  logic [RuleIdxW:0]   tbl_cnt;
  logic [63:0]         tbl_base;
  logic [63:0]         tbl_len;
  logic                rule_match;
  logic                last_rule;

  always_comb begin
    tbl_cnt  = '0;
    tbl_base = '0;
    tbl_len  = '0;
    case (kind_q)
      EXEC: begin
        tbl_cnt  = ExecCnt;
        tbl_base = CVA6Cfg.ExecuteRegionAddrBase[64*idx_q +: 64];
        tbl_len  = CVA6Cfg.ExecuteRegionLength[64*idx_q +: 64];
      end
      CACHED: begin
        tbl_cnt  = CachedCnt;
        tbl_base = CVA6Cfg.CachedRegionAddrBase[64*idx_q +: 64];
        tbl_len  = CVA6Cfg.CachedRegionLength[64*idx_q +: 64];
      end
      NONIDEM: begin
        tbl_cnt  = NonIdCnt;
        tbl_base = CVA6Cfg.NonIdempotentAddrBase[64*idx_q +: 64];
        tbl_len  = CVA6Cfg.NonIdempotentLength[64*idx_q +: 64];
      end
      default: ;
    endcase
  end

  cfg_region_match u_match (
    .addr_i  (addr_q),
    .base_i  (tbl_base),
    .len_i   (tbl_len),
    .match_o (rule_match)
  );

  // An empty table still spends one SCAN cycle on index 0 before missing.
  assign last_rule = ({1'b0, idx_q} + 1'b1) >= tbl_cnt;
  assign req_ready = (state_q == IDLE) && !rst_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    kind_d  = kind_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    rule_d  = rule_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i && req_ready) begin
          addr_d  = bus.req_addr_i;
          kind_d  = region_kind_e'(bus.req_kind_i);
          idx_d   = '0;
          hit_d   = 1'b0;
          rule_d  = '0;
          err_d   = (region_kind_e'(bus.req_kind_i) == RSVD);
          state_d = (region_kind_e'(bus.req_kind_i) == RSVD) ? RESP : SCAN;
        end
      end
      SCAN: begin
        if (tbl_cnt != '0 && rule_match) begin
          hit_d   = 1'b1;
          rule_d  = idx_q;
          state_d = RESP;
        end else if (last_rule) begin
          hit_d   = 1'b0;
          rule_d  = '0;
          state_d = RESP;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      kind_q  <= EXEC;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      rule_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      kind_q  <= kind_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      rule_q  <= rule_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_hit_o   = hit_q;
  assign bus.rsp_rule_o  = rule_q;
  assign bus.rsp_err_o   = err_q;

`ifdef CFG_REGION_QUERY_STATS_EN
  logic [15:0] stat_hits_q, stat_hits_d;
  logic [15:0] stat_misses_q, stat_misses_d;
  logic        rsp_fire;

  assign rsp_fire = (state_q == RESP) && bus.rsp_ready_i;

  always_comb begin
    stat_hits_d   = stat_hits_q;
    stat_misses_d = stat_misses_q;
    if (rsp_fire) begin
      if (hit_q) stat_hits_d   = sat_inc16(stat_hits_q);
      else       stat_misses_d = sat_inc16(stat_misses_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else begin
      stat_hits_q   <= stat_hits_d;
      stat_misses_q <= stat_misses_d;
    end
  end

  assign stat_hits_o   = stat_hits_q;
  assign stat_misses_o = stat_misses_q;
`else
  assign stat_hits_o   = '0;
  assign stat_misses_o = '0;
`endif

endmodule

// File: tb/tb_cfg_region_query.sv
// Directed bench for cfg_region_query against the default platform map.
module tb_cfg_region_query;
  logic        clk;
  logic        rst;
  logic [15:0] stat_hits;
  logic [15:0] stat_misses;
  int          n_chk;
  int          n_fail;
  int          exp_hits;
  int          exp_miss;

  cfg_region_query_if bus();

  cfg_region_query dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus),
    .stat_hits_o   (stat_hits),
    .stat_misses_o (stat_misses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_stats(input string tag);
`ifdef CFG_REGION_QUERY_STATS_EN
    chk({tag, "_hits"}, 64'(stat_hits), 64'(exp_hits));
    chk({tag, "_miss"}, 64'(stat_misses), 64'(exp_miss));
`else
    chk({tag, "_hits"}, 64'(stat_hits), 64'd0);
    chk({tag, "_miss"}, 64'(stat_misses), 64'd0);
`endif
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
  task automatic query(input string tag, input logic [1:0] kind, input logic [63:0] addr,
                       input logic ehit, input logic [3:0] erule, input logic eerr,
                       input int elat, input int hold);
    int lat;
    bus.req_valid_i = 1'b1;
    bus.req_kind_i  = kind;
    bus.req_addr_i  = addr;
    chk({tag, "_acc_rdy"}, 64'(bus.req_ready_o), 64'd1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    lat = 1;
    while (!bus.rsp_valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"},  64'(lat), 64'(elat));
    chk({tag, "_hit"},  64'(bus.rsp_hit_o), 64'(ehit));
    chk({tag, "_rule"}, 64'(bus.rsp_rule_o), 64'(erule));
    chk({tag, "_err"},  64'(bus.rsp_err_o), 64'(eerr));
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, "_hold_vld"},  64'(bus.rsp_valid_o), 64'd1);
      chk({tag, "_hold_hit"},  64'(bus.rsp_hit_o), 64'(ehit));
      chk({tag, "_hold_rule"}, 64'(bus.rsp_rule_o), 64'(erule));
      chk({tag, "_hold_err"},  64'(bus.rsp_err_o), 64'(eerr));
      chk({tag, "_hold_rdy"},  64'(bus.req_ready_o), 64'd0);
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    if (ehit && !eerr) exp_hits = (exp_hits == 65535) ? 65535 : exp_hits + 1;
    else               exp_miss = (exp_miss == 65535) ? 65535 : exp_miss + 1;
    chk({tag, "_idle_vld"}, 64'(bus.rsp_valid_o), 64'd0);
    chk({tag, "_idle_rdy"}, 64'(bus.req_ready_o), 64'd1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; exp_hits = 0; exp_miss = 0;
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_kind_i  = 2'd0;
    bus.rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy",  64'(bus.req_ready_o), 64'd0);
    chk("rst_vld",  64'(bus.rsp_valid_o), 64'd0);
    chk("rst_hit",  64'(bus.rsp_hit_o), 64'd0);
    chk("rst_rule", 64'(bus.rsp_rule_o), 64'd0);
    chk("rst_err",  64'(bus.rsp_err_o), 64'd0);
    chk_stats("rst");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rdy", 64'(bus.req_ready_o), 64'd1);

    // kind, addr, hit, rule, err, latency, hold
    query("ex_dram",    2'd0, 64'h8000_0100,  1'b1, 4'd2, 1'b0, 4, 0);
    query("ex_dram_end",2'd0, 64'hC000_0000,  1'b0, 4'd0, 1'b0, 4, 0);
    query("ex_dbg",     2'd0, 64'h0000_0FFF,  1'b1, 4'd0, 1'b0, 2, 0);
    query("ex_dbg_end", 2'd0, 64'h0000_1000,  1'b0, 4'd0, 1'b0, 4, 0);
    query("ex_rom",     2'd0, 64'h0001_0000,  1'b1, 4'd1, 1'b0, 3, 0);
    query("ex_rom_top", 2'd0, 64'h0001_FFFF,  1'b1, 4'd1, 1'b0, 3, 0);
    query("ex_high",    2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd0, 1'b0, 4, 0);
    query("ni_zero",    2'd2, 64'h0,          1'b0, 4'd0, 1'b0, 3, 0);
    query("rsvd",       2'd3, 64'h8000_0000,  1'b0, 4'd0, 1'b1, 1, 0);
    query("ca_base",    2'd1, 64'h8000_0000,  1'b1, 4'd0, 1'b0, 2, 0);
    query("ca_top",     2'd1, 64'hBFFF_FFFF,  1'b1, 4'd0, 1'b0, 2, 0);
    query("ca_miss",    2'd1, 64'h0000_1000,  1'b0, 4'd0, 1'b0, 2, 0);
    query("hold",       2'd0, 64'h8000_0200,  1'b1, 4'd2, 1'b0, 4, 5);
    chk_stats("mid");

    // Reset while the DRAM query is still scanning rule 0.
    bus.req_valid_i = 1'b1;
    bus.req_kind_i  = 2'd0;
    bus.req_addr_i  = 64'h8000_0000;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_rst_rdy", 64'(bus.req_ready_o), 64'd0);
    chk("abort_rst_vld", 64'(bus.rsp_valid_o), 64'd0);
    rst = 1'b0;
    exp_hits = 0; exp_miss = 0;
    @(posedge clk); #1;
    chk("abort_rdy", 64'(bus.req_ready_o), 64'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
    end
    chk_stats("abort");

    query("st_h0", 2'd0, 64'h0000_0010, 1'b1, 4'd0, 1'b0, 2, 0);
    query("st_m0", 2'd1, 64'h0000_0010, 1'b0, 4'd0, 1'b0, 2, 0);
    query("st_h1", 2'd1, 64'h9000_0000, 1'b1, 4'd0, 1'b0, 2, 0);
    query("st_m1", 2'd3, 64'h0000_0000, 1'b0, 4'd0, 1'b1, 1, 0);
    query("st_h2", 2'd0, 64'h0001_8000, 1'b1, 4'd1, 1'b0, 3, 0);
    chk_stats("st_3h2m");
`ifdef CFG_REGION_QUERY_STATS_EN
    chk("st_exp_hits", 64'(exp_hits), 64'd3);
    chk("st_exp_miss", 64'(exp_miss), 64'd2);
    force dut.stat_hits_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.stat_hits_q;
    exp_hits = 65535;
    query("st_sat", 2'd0, 64'h0000_0000, 1'b1, 4'd0, 1'b0, 2, 0);
    chk_stats("st_sat");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cfg_region_query.md
CFG_REGION_QUERY -- requirements
Module: cfg_region_query

Interface
REQ-001 The block SHALL have one parameter: CVA6Cfg (config_pkg::cva6_cfg_t, default cva6_config_pkg::cva6_cfg), which supplies the region rule tables.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 req_valid_i  input  1  query present.
REQ-006 req_ready_o  output  1  block can accept a query.
REQ-007 req_addr_i  input  64  physical address to classify.
REQ-008 req_kind_i  input  2  table select: 0 = execute, 1 = cached, 2 = non-idempotent, 3 = reserved.
REQ-009 rsp_valid_o  output  1  response present.
REQ-010 rsp_ready_i  input  1  consumer accepts the response.
REQ-011 rsp_hit_o  output  1  address lies inside a rule of the selected table.
REQ-012 rsp_rule_o  output  4  index of the matching rule; 0 on a miss.
REQ-013 rsp_err_o  output  1  req_kind_i was 3.
REQ-014 stat_hits_o  output  16  count of hit responses.
REQ-015 stat_misses_o  output  16  count of miss and error responses.

Function
REQ-016 The FSM SHALL have three states: IDLE, SCAN and RESP. Reset state is IDLE.
REQ-017 req_ready_o SHALL be 1 only in IDLE. A query is accepted on a cycle where req_valid_i and req_ready_o are both 1.
REQ-018 On accept, the block SHALL register the address and kind, clear the rule index, and enter SCAN; for kind 3 it SHALL enter RESP directly with hit=0 and err=1.
REQ-019 In SCAN, the block SHALL evaluate exactly one rule per cycle, in index order 0, 1, 2, and so on.
REQ-020 Per-table rule counts and arrays: execute uses NrExecuteRegionRules with ExecuteRegionAddrBase/ExecuteRegionLength; cached uses NrCachedRegionRules with CachedRegionAddrBase/CachedRegionLength; non-idempotent uses NrNonIdempotentRules with NonIdempotentAddrBase/NonIdempotentLength.
REQ-021 Rule i SHALL occupy bits [64*i +: 64] of its array.
REQ-022 Rule i SHALL match when base <= addr < base+length. The sum SHALL be computed in 65 bits so it cannot wrap. A rule with length 0 never matches.
REQ-023 On the first matching rule, the block SHALL go to RESP with hit=1 and rule=i. Later rules are not evaluated.
REQ-024 If the last rule does not match, the block SHALL go to RESP with hit=0 and rule=0. With a rule count of 0, SCAN SHALL last one cycle and then miss.
REQ-025 rsp_valid_o SHALL be 1 only in RESP. A hit on rule i is therefore valid i+2 cycles after the accept cycle. A miss is valid N+1 cycles after accept, where N = max(count, 1).
REQ-026 While rsp_valid_o=1 and rsp_ready_i=0, all rsp_* outputs SHALL hold stable.
REQ-027 On rsp_valid_o & rsp_ready_i the block SHALL return to IDLE. A new query is accepted no earlier than the following cycle, so there is no accept/response overlap.
REQ-028 Rule index width SHALL be 4 bits; rule counts above 16 are a compile-time error.

Reset
REQ-029 While rst_i=1, on the next edge: state becomes IDLE; rsp_valid_o, rsp_hit_o, rsp_rule_o and rsp_err_o become 0; both stat counters become 0.
REQ-030 Reset asserted mid-SCAN or mid-RESP SHALL abort the query with no response.
REQ-031 While rst_i=1, req_ready_o SHALL be 0.

Configuration
REQ-032 Macro CFG_REGION_QUERY_STATS_EN SHALL control the statistics counters.
REQ-033 With the macro defined: each response handshake SHALL increment stat_hits_o (hit) or stat_misses_o (miss or error), saturating at 16'hFFFF.
REQ-034 Without the macro: the counters SHALL be absent and both stat ports SHALL be constant 0. Ports exist in both builds.

Structure
REQ-035 A shared package cfg_region_query_pkg SHALL hold: the region_kind_e enum (EXEC=0, CACHED=1, NONIDEM=2, RSVD=3), the FSM state enum, and the constant RuleIdxW=4.
REQ-036 Sub-module cfg_region_match SHALL hold the combinational single-rule compare (addr, base, length -> match). It is instantiated once and fed by the current rule index.

Verification
REQ-037 Execute query 64'h8000_0100 with the default config -> rsp_hit_o=1, rsp_rule_o=2, rsp_valid_o 4 cycles after accept.
REQ-038 Execute query 64'hC000_0000 (end exclusive) -> hit=0, rule=0, valid 4 cycles after accept; execute query 64'h0FFF -> hit, rule=0, valid 2 cycles after accept.
REQ-039 Non-idempotent query 64'h0 with both lengths 0 -> miss; kind 3 -> err=1, hit=0, valid 1 cycle after accept.
REQ-040 Hold rsp_ready_i=0 for 5 cycles on a hit -> outputs stable and req_ready_o=0 throughout; handshake -> IDLE next cycle.
REQ-041 Assert rst_i during SCAN of query 64'h8000_0000 -> no response, req_ready_o=1 one cycle after rst_i deasserts.
REQ-042 With CFG_REGION_QUERY_STATS_EN: 3 hits and 2 misses -> stat_hits_o=3, stat_misses_o=2; force the counter to 16'hFFFF, then one more hit -> stays 16'hFFFF. Without the macro, both ports read 0.
